// File: rtl/gshare_bpred_unit.sv
// gshare_bpred_unit
//   Global-history (gshare) branch predictor for the five-stage pipeline.
//   Holds a global history register (BHR), a pattern table (PT) of saturating
//   counters indexed by pc XOR history, and a direct-mapped tagged BTB.
//   After reset a sweep initialises the PT to weakly-not-taken and clears the
//   BTB valid bits; lookups and updates are honoured only once ready is high.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   ready             tables initialised (FSM in READY)
//   lk_pc             fetch PC (lookup port, combinational)
//   lk_hit            BTB valid and tag match
//   lk_taken          predicted taken
//   lk_target         predicted next PC
//   lk_pt_idx         gshare PT index, carried down the pipe to resolve
//   rs_valid          resolving control-flow instruction present
//   rs_cond           1 = conditional branch, 0 = JAL/JALR
//   rs_pc             resolving instruction PC
//   rs_pt_idx         PT index captured at lookup
//   rs_taken          actual direction
//   rs_target         actual taken target
//   rs_pred_taken     predicted direction carried from lookup
//   rs_pred_target    predicted target carried from lookup
//   rs_mispredict     flush/redirect request (combinational)
//   rs_redirect_pc    correct next PC (combinational)
//   bhr_out           current global history
//   stat_branches     resolved control-flow count
//   stat_correct      correctly predicted count
//   stat_mispred      mispredicted count
//
// Handshake: there is no backpressure. A resolve is a single-cycle event:
// every cycle in which rs_valid=1 and ready=1 commits exactly one update at
// the next rising clk edge; rs_valid while ready=0 commits nothing.
module gshare_bpred_unit #(
  parameter int DBITS          = 32,
  parameter int BHR_BITS       = 8,
  parameter int PT_INDEX_BITS  = 8,
  parameter int BTB_INDEX_BITS = 4,
  parameter int CTR_BITS       = 2,
  parameter int STAT_BITS      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [DBITS-1:0]         lk_pc,
  output logic                     lk_hit,
  output logic                     lk_taken,
  output logic [DBITS-1:0]         lk_target,
  output logic [PT_INDEX_BITS-1:0] lk_pt_idx,
  input  logic                     rs_valid,
  input  logic                     rs_cond,
  input  logic [DBITS-1:0]         rs_pc,
  input  logic [PT_INDEX_BITS-1:0] rs_pt_idx,
  input  logic                     rs_taken,
  input  logic [DBITS-1:0]         rs_target,
  input  logic                     rs_pred_taken,
  input  logic [DBITS-1:0]         rs_pred_target,
  output logic                     rs_mispredict,
  output logic [DBITS-1:0]         rs_redirect_pc,
  output logic [BHR_BITS-1:0]      bhr_out,
  output logic [STAT_BITS-1:0]     stat_branches,
  output logic [STAT_BITS-1:0]     stat_correct,
  output logic [STAT_BITS-1:0]     stat_mispred
);

  localparam int PT_ENTRIES  = 1 << PT_INDEX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS    = DBITS - BTB_INDEX_BITS - 2;
  // The sweep walks the larger of the two tables; the smaller one is written
  // only while the index is still inside its range.
  localparam int INIT_BITS   = (PT_INDEX_BITS > BTB_INDEX_BITS) ? PT_INDEX_BITS : BTB_INDEX_BITS;

  localparam logic [INIT_BITS-1:0] INIT_LAST   = '1;
  localparam logic [CTR_BITS-1:0]  CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK_NT = CTR_MAX >> 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [INIT_BITS-1:0]    r_init_idx;
  logic                    r_ready;
  logic [BHR_BITS-1:0]     r_bhr;
  logic [STAT_BITS-1:0]    r_stat_branches;
  logic [STAT_BITS-1:0]    r_stat_correct;
  logic [STAT_BITS-1:0]    r_stat_mispred;

  logic [CTR_BITS-1:0]     r_pt         [PT_ENTRIES];
  logic [BTB_ENTRIES-1:0]  r_btb_valid;
  logic [TAG_BITS-1:0]     r_btb_tag    [BTB_ENTRIES];
  logic [DBITS-1:0]        r_btb_target [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0]  r_btb_kind;   // 1 = unconditional jump

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic                      w_upd;
  logic                      w_init_pt_en;
  logic                      w_init_btb_en;
  logic [PT_INDEX_BITS-1:0]  w_lk_pt_idx;
  logic [BTB_INDEX_BITS-1:0] w_lk_btb_idx;
  logic [TAG_BITS-1:0]       w_lk_tag;
  logic [CTR_BITS-1:0]       w_lk_ctr;
  logic                      w_lk_hit;
  logic                      w_lk_taken;
  logic [BTB_INDEX_BITS-1:0] w_rs_btb_idx;
  logic [TAG_BITS-1:0]       w_rs_tag;
  logic [CTR_BITS-1:0]       w_ctr_old;
  logic [CTR_BITS-1:0]       w_ctr_next;
  logic [BHR_BITS-1:0]       w_bhr_next;
  logic                      w_mispredict;

  assign w_upd         = rs_valid & r_ready;
  assign w_init_pt_en  = ((r_init_idx >> PT_INDEX_BITS) == '0);
  assign w_init_btb_en = ((r_init_idx >> BTB_INDEX_BITS) == '0);

  // ---------------------------------------------------------------------------
  // Lookup (combinational, registered state only)
  // ---------------------------------------------------------------------------
  assign w_lk_pt_idx  = lk_pc[PT_INDEX_BITS+1:2] ^ PT_INDEX_BITS'(r_bhr);
  assign w_lk_btb_idx = lk_pc[BTB_INDEX_BITS+1:2];
  assign w_lk_tag     = lk_pc[DBITS-1:BTB_INDEX_BITS+2];
  assign w_lk_ctr     = r_pt[w_lk_pt_idx];

  assign w_lk_hit   = r_ready & r_btb_valid[w_lk_btb_idx]
                    & (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
  // Jumps are always taken once they live in the BTB; conditional branches
  // follow the counter MSB.
  assign w_lk_taken = w_lk_hit & (w_lk_ctr[CTR_BITS-1] | r_btb_kind[w_lk_btb_idx]);

  assign lk_hit    = w_lk_hit;
  assign lk_taken  = w_lk_taken;
  assign lk_target = w_lk_taken ? r_btb_target[w_lk_btb_idx] : (lk_pc + DBITS'(4));
  assign lk_pt_idx = w_lk_pt_idx;

  // ---------------------------------------------------------------------------
  // Resolve (combinational)
  // ---------------------------------------------------------------------------
  assign w_mispredict = rs_valid & ((rs_taken != rs_pred_taken)
                                  | (rs_taken & (rs_pred_target != rs_target)));
  assign rs_mispredict  = w_mispredict;
  assign rs_redirect_pc = rs_valid ? (rs_taken ? rs_target : (rs_pc + DBITS'(4)))
                                   : '0;

  assign w_rs_btb_idx = rs_pc[BTB_INDEX_BITS+1:2];
  assign w_rs_tag     = rs_pc[DBITS-1:BTB_INDEX_BITS+2];

  // Saturating counter step.
  assign w_ctr_old = r_pt[rs_pt_idx];
  always_comb begin
    w_ctr_next = w_ctr_old;
    if (rs_taken) begin
      if (w_ctr_old != CTR_MAX) w_ctr_next = w_ctr_old + CTR_BITS'(1);
    end else begin
      if (w_ctr_old != '0)      w_ctr_next = w_ctr_old - CTR_BITS'(1);
    end
  end

  generate
    if (BHR_BITS == 1) begin : g_bhr1
      assign w_bhr_next = rs_taken;
    end else begin : g_bhrn
      assign w_bhr_next = {r_bhr[BHR_BITS-2:0], rs_taken};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Init/ready FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + INIT_BITS'(1);
          if (r_init_idx == INIT_LAST) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;

  // ---------------------------------------------------------------------------
  // Pattern table: sweep write during INIT, counter update once ready.
  // Not reset directly; a reset always re-runs the sweep before use.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!r_ready) begin
      if (w_init_pt_en) r_pt[r_init_idx[PT_INDEX_BITS-1:0]] <= CTR_WEAK_NT;
    end else if (w_upd && rs_cond) begin
      r_pt[rs_pt_idx] <= w_ctr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // BTB: only taken resolves allocate, so not-taken never evicts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!r_ready) begin
      if (w_init_btb_en) r_btb_valid[r_init_idx[BTB_INDEX_BITS-1:0]] <= 1'b0;
    end else if (w_upd && rs_taken) begin
      r_btb_valid[w_rs_btb_idx]  <= 1'b1;
      r_btb_tag[w_rs_btb_idx]    <= w_rs_tag;
      r_btb_target[w_rs_btb_idx] <= rs_target;
      r_btb_kind[w_rs_btb_idx]   <= ~rs_cond;
    end
  end

  // ---------------------------------------------------------------------------
  // Global history and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bhr <= '0;
    end else if (w_upd && rs_cond) begin
      r_bhr <= w_bhr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_branches <= '0;
      r_stat_correct  <= '0;
      r_stat_mispred  <= '0;
    end else if (w_upd) begin
      r_stat_branches <= r_stat_branches + STAT_BITS'(1);
      if (w_mispredict) r_stat_mispred <= r_stat_mispred + STAT_BITS'(1);
      else              r_stat_correct <= r_stat_correct + STAT_BITS'(1);
    end
  end

  assign bhr_out       = r_bhr;
  assign stat_branches = r_stat_branches;
  assign stat_correct  = r_stat_correct;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_gshare_bpred_unit.sv
// tb_gshare_bpred_unit
//   Directed-vector bench for gshare_bpred_unit at default parameters.
//   Expected values are hand-derived from the predictor behaviour.
module tb_gshare_bpred_unit;

  localparam int DBITS = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              ready;
  logic [DBITS-1:0]  lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [DBITS-1:0]  lk_target;
  logic [7:0]        lk_pt_idx;
  logic              rs_valid;
  logic              rs_cond;
  logic [DBITS-1:0]  rs_pc;
  logic [7:0]        rs_pt_idx;
  logic              rs_taken;
  logic [DBITS-1:0]  rs_target;
  logic              rs_pred_taken;
  logic [DBITS-1:0]  rs_pred_target;
  logic              rs_mispredict;
  logic [DBITS-1:0]  rs_redirect_pc;
  logic [7:0]        bhr_out;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_correct;
  logic [31:0]       stat_mispred;

  gshare_bpred_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .lk_pc          (lk_pc),
    .lk_hit         (lk_hit),
    .lk_taken       (lk_taken),
    .lk_target      (lk_target),
    .lk_pt_idx      (lk_pt_idx),
    .rs_valid       (rs_valid),
    .rs_cond        (rs_cond),
    .rs_pc          (rs_pc),
    .rs_pt_idx      (rs_pt_idx),
    .rs_taken       (rs_taken),
    .rs_target      (rs_target),
    .rs_pred_taken  (rs_pred_taken),
    .rs_pred_target (rs_pred_target),
    .rs_mispredict  (rs_mispredict),
    .rs_redirect_pc (rs_redirect_pc),
    .bhr_out        (bhr_out),
    .stat_branches  (stat_branches),
    .stat_correct   (stat_correct),
    .stat_mispred   (stat_mispred)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lookup(input string tag, input logic [31:0] pc, input logic exp_hit,
                            input logic exp_taken, input logic [31:0] exp_target);
    lk_pc = pc;
    #1;
    chk({tag, "_hit"},    lk_hit,    exp_hit);
    chk({tag, "_taken"},  lk_taken,  exp_taken);
    chk({tag, "_target"}, lk_target, exp_target);
  endtask

  task automatic chk_stats(input string tag, input int br, input int ok, input int mis);
    chk({tag, "_branches"}, stat_branches, br);
    chk({tag, "_correct"},  stat_correct,  ok);
    chk({tag, "_mispred"},  stat_mispred,  mis);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drive_rs(input logic cond, input logic [31:0] pc, input logic [7:0] idx,
                          input logic taken, input logic [31:0] target,
                          input logic ptaken, input logic [31:0] ptarget);
    @(negedge clk);
    rs_valid       = 1'b1;
    rs_cond        = cond;
    rs_pc          = pc;
    rs_pt_idx      = idx;
    rs_taken       = taken;
    rs_target      = target;
    rs_pred_taken  = ptaken;
    rs_pred_target = ptarget;
    #1;
  endtask

  // Commit the driven resolve on the next edge, then drop rs_valid.
  task automatic tick();
    @(posedge clk);
    #1;
    rs_valid = 1'b0;
    #1;
  endtask

  // Release from reset has just happened (right after a posedge). Walk the
  // 256-cycle sweep, pulsing rs_valid in the middle of it.
  task automatic run_init(input string tag);
    rs_cond        = 1'b1;
    rs_pc          = 32'h500;
    rs_pt_idx      = 8'h40;
    rs_taken       = 1'b1;
    rs_target      = 32'h600;
    rs_pred_taken  = 1'b0;
    rs_pred_target = 32'h504;
    lk_pc          = 32'h100;
    for (int i = 1; i <= 256; i++) begin
      rs_valid = (i >= 10 && i <= 12);
      @(posedge clk);
      #1;
      if (i == 10) begin
        chk({tag, "_init_mispred"},  rs_mispredict,  1'b1);
        chk({tag, "_init_redirect"}, rs_redirect_pc, 32'h600);
      end
      if (i == 100) begin
        chk({tag, "_init_lk_hit"},    lk_hit,    1'b0);
        chk({tag, "_init_lk_taken"},  lk_taken,  1'b0);
        chk({tag, "_init_lk_target"}, lk_target, 32'h104);
      end
      if (i == 255) chk({tag, "_ready_at_255"}, ready, 1'b0);
      if (i == 256) chk({tag, "_ready_at_256"}, ready, 1'b1);
    end
    rs_valid = 1'b0;
    #1;
    chk_stats({tag, "_post_init"}, 0, 0, 0);
    chk({tag, "_post_init_bhr"}, bhr_out, 8'h00);
    // A resolve during INIT must not have allocated a BTB entry.
    chk_lookup({tag, "_post_init_0x500"}, 32'h500, 1'b0, 1'b0, 32'h504);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rs_valid = 1'b0; rs_cond = 1'b0; rs_pc = '0; rs_pt_idx = '0; rs_taken = 1'b0;
    rs_target = '0; rs_pred_taken = 1'b0; rs_pred_target = '0;
    lk_pc = 32'h100;
    #2;

    // Reset state
    chk("rst_ready", ready, 1'b0);
    chk("rst_bhr", bhr_out, 8'h00);
    chk_stats("rst", 0, 0, 0);
    chk_lookup("rst_lk", 32'h100, 1'b0, 1'b0, 32'h104);

    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_init("boot");

    // Conditional taken branch 0x100 -> 0x80, resolved three times against
    // PT index 0x47 (the index 0x100 maps to once BHR reaches 0x07).
    chk_lookup("c0", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("c0_idx", lk_pt_idx, 8'h40);
    drive_rs(1'b1, 32'h100, 8'h47, 1'b1, 32'h80, 1'b0, 32'h104);
    chk("c1_mispred", rs_mispredict, 1'b1);
    chk("c1_redirect", rs_redirect_pc, 32'h80);
    tick();
    chk("c1_bhr", bhr_out, 8'h01);
    // BTB now hits; PT[0x41] is still weakly not-taken.
    chk_lookup("c1_lk", 32'h100, 1'b1, 1'b0, 32'h104);
    chk("c1_idx", lk_pt_idx, 8'h41);
    drive_rs(1'b1, 32'h100, 8'h47, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("c2_mispred", rs_mispredict, 1'b0);
    tick();
    chk("c2_bhr", bhr_out, 8'h03);
    drive_rs(1'b1, 32'h100, 8'h47, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    chk("c3_bhr", bhr_out, 8'h07);
    chk_lookup("c3_lk", 32'h100, 1'b1, 1'b1, 32'h80);
    chk("c3_idx", lk_pt_idx, 8'h47);
    chk_stats("c3", 3, 2, 1);

    // JAL 0x200 -> 0x400, predicted not taken.
    drive_rs(1'b0, 32'h200, 8'h87, 1'b1, 32'h400, 1'b0, 32'h204);
    chk("j_mispred", rs_mispredict, 1'b1);
    chk("j_redirect", rs_redirect_pc, 32'h400);
    chk_lookup("j_same_cycle", 32'h200, 1'b0, 1'b0, 32'h204);
    tick();
    chk_lookup("j_next", 32'h200, 1'b1, 1'b1, 32'h400);
    chk("j_bhr", bhr_out, 8'h07);
    chk_stats("j", 4, 2, 2);

    // Not-taken branch 0x300 predicted taken to 0x340 (same BTB set as 0x200).
    drive_rs(1'b1, 32'h300, 8'hC7, 1'b0, 32'h340, 1'b1, 32'h340);
    chk("nt_mispred", rs_mispredict, 1'b1);
    chk("nt_redirect", rs_redirect_pc, 32'h304);
    tick();
    chk_stats("nt", 5, 2, 3);
    chk("nt_bhr", bhr_out, 8'h0E);
    chk_lookup("nt_0x300", 32'h300, 1'b0, 1'b0, 32'h304);
    chk_lookup("nt_0x200", 32'h200, 1'b1, 1'b1, 32'h400);

    // Combinational resolve probes, no edge committed.
    @(negedge clk);
    rs_cond = 1'b1; rs_pc = 32'h700; rs_taken = 1'b1; rs_target = 32'h800;
    rs_pred_taken = 1'b1; rs_pred_target = 32'h804; rs_valid = 1'b1;
    #1;
    chk("pr_tgt_mispred", rs_mispredict, 1'b1);
    chk("pr_tgt_redirect", rs_redirect_pc, 32'h800);
    rs_taken = 1'b0; rs_pred_taken = 1'b0;
    #1;
    chk("pr_nt_mispred", rs_mispredict, 1'b0);
    chk("pr_nt_redirect", rs_redirect_pc, 32'h704);
    rs_valid = 1'b0;
    #1;
    chk("pr_idle_mispred", rs_mispredict, 1'b0);
    chk("pr_idle_redirect", rs_redirect_pc, 32'h0);

    // Aliasing: 0x40 and 0x440 share BTB set 0 with different tags.
    drive_rs(1'b0, 32'h40, 8'h1A, 1'b1, 32'h1000, 1'b0, 32'h44);
    tick();
    chk_lookup("al1_0x40", 32'h40, 1'b1, 1'b1, 32'h1000);
    chk_lookup("al1_0x440", 32'h440, 1'b0, 1'b0, 32'h444);
    chk_lookup("al1_0x200", 32'h200, 1'b0, 1'b0, 32'h204);
    drive_rs(1'b0, 32'h440, 8'h1A, 1'b1, 32'h2000, 1'b1, 32'h2000);
    chk("al2_mispred", rs_mispredict, 1'b0);
    tick();
    chk_lookup("al2_0x440", 32'h440, 1'b1, 1'b1, 32'h2000);
    chk_lookup("al2_0x40", 32'h40, 1'b0, 1'b0, 32'h44);
    chk_stats("al", 7, 3, 4);

    // Reset 100 cycles after ready: everything back to INIT and a full sweep.
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst2_ready", ready, 1'b0);
    chk("rst2_bhr", bhr_out, 8'h00);
    chk_stats("rst2", 0, 0, 0);
    chk_lookup("rst2_lk", 32'h440, 1'b0, 1'b0, 32'h444);
    @(posedge clk); #1;
    reset = 1'b0;
    run_init("rerun");
    chk_lookup("rerun_0x440", 32'h440, 1'b0, 1'b0, 32'h444);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
